// File: rtl/cache_mem_arbiter_pkg.sv
// Shared cache package for the cache-to-memory arbiter.
// Contents:
//   LINE_WORDS_DEF - default number of 32-bit words in one refill or writeback line
//   arb_state_t    - bus FSM states (one bus transaction in flight at a time)
//   arb_gnt_t      - which requester won arbitration this cycle
package cache_mem_arbiter_pkg;

  localparam int LINE_WORDS_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_ADDR,
    ST_WR_RESP
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IC,
    GNT_DC,
    GNT_WR
  } arb_gnt_t;

endpackage

// File: rtl/cache_mem_arbiter_pick.sv
// mem_arb_pick: chooses one requester when the arbiter is free to grant.
// The DCache writeback always wins. Between the two refill reads the choice
// depends on the build:
//   MEM_ARB_RR_EN undefined : DCache read has fixed priority over ICache read.
//   MEM_ARB_RR_EN defined   : a 1-bit pointer alternates between the two reads.
//                             It toggles after every granted read, and it
//                             favours the ICache after reset.
// Ports:
//   clk, reset    - clock and async active-high reset (round-robin build only)
//   i_en          - arbiter is idle and allowed to grant this cycle
//   i_ic_rd_req   - ICache refill request
//   i_dc_rd_req   - DCache refill request
//   i_dc_wr_req   - DCache writeback request
//   o_gnt         - winner (GNT_NONE when nothing is granted)
module mem_arb_pick
  import cache_mem_arbiter_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic     clk,
  input  logic     reset,
`endif
  input  logic     i_en,
  input  logic     i_ic_rd_req,
  input  logic     i_dc_rd_req,
  input  logic     i_dc_wr_req,
  output arb_gnt_t o_gnt
);

`ifdef MEM_ARB_RR_EN
  // r_ptr = 0 favours the ICache, r_ptr = 1 favours the DCache.
  logic r_ptr;

  always_comb begin
    o_gnt = GNT_NONE;
    if (i_en) begin
      if (i_dc_wr_req)                    o_gnt = GNT_WR;
      else if (i_ic_rd_req && i_dc_rd_req) o_gnt = r_ptr ? GNT_DC : GNT_IC;
      else if (i_dc_rd_req)               o_gnt = GNT_DC;
      else if (i_ic_rd_req)               o_gnt = GNT_IC;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= 1'b0;
    end else if (o_gnt == GNT_IC || o_gnt == GNT_DC) begin
      r_ptr <= ~r_ptr;
    end
  end
`else
  always_comb begin
    o_gnt = GNT_NONE;
    if (i_en) begin
      if (i_dc_wr_req)      o_gnt = GNT_WR;
      else if (i_dc_rd_req) o_gnt = GNT_DC;
      else if (i_ic_rd_req) o_gnt = GNT_IC;
    end
  end
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one memory-side bus between the ICache refill
// port, the DCache refill port and the DCache writeback port. Only one bus
// transaction is outstanding at any time.
// Optional feature: define MEM_ARB_RR_EN for round-robin between ICache and
// DCache reads. Without it, DCache reads have fixed priority. Writeback is
// always highest priority.
// Ports:
//   clk, reset                     - clock, async active-high reset
//   ic_rd_req/addr/rdy             - ICache refill request handshake
//   ic_ret_valid                   - refill beat is for the ICache
//   dc_rd_req/addr/rdy             - DCache refill request handshake
//   dc_ret_valid                   - refill beat is for the DCache
//   ret_last, ret_data             - shared refill beat info (last beat, data)
//   dc_wr_req/addr/data/rdy        - DCache writeback request handshake
//   bus_rd_req/addr/rdy            - memory read burst request handshake
//   bus_ret_valid, bus_ret_data    - memory read beat return
//   bus_wr_req/addr/data/rdy       - memory write burst request handshake
//   bus_wr_done                    - memory write burst completed
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ic_rd_req,
  input  logic [31:0]             ic_rd_addr,
  output logic                    ic_rd_rdy,
  output logic                    ic_ret_valid,
  input  logic                    dc_rd_req,
  input  logic [31:0]             dc_rd_addr,
  output logic                    dc_rd_rdy,
  output logic                    dc_ret_valid,
  output logic                    ret_last,
  output logic [31:0]             ret_data,
  input  logic                    dc_wr_req,
  input  logic [31:0]             dc_wr_addr,
  input  logic [32*LINE_WORDS-1:0] dc_wr_data,
  output logic                    dc_wr_rdy,
  output logic                    bus_rd_req,
  output logic [31:0]             bus_rd_addr,
  input  logic                    bus_rd_rdy,
  input  logic                    bus_ret_valid,
  input  logic [31:0]             bus_ret_data,
  output logic                    bus_wr_req,
  output logic [31:0]             bus_wr_addr,
  output logic [32*LINE_WORDS-1:0] bus_wr_data,
  input  logic                    bus_wr_rdy,
  input  logic                    bus_wr_done
);

  localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  arb_state_t              r_state;
  arb_state_t              w_next;
  logic [CNT_W-1:0]        r_beat;
  logic [31:0]             r_addr;
  logic [32*LINE_WORDS-1:0] r_wdata;
  logic                    r_is_dc;
  // High for the first IDLE cycle after a transaction, so two transactions
  // are always separated by at least one IDLE cycle with no grant.
  logic                    r_cool;
  logic                    w_pick_en;
  logic                    w_last_beat;
  arb_gnt_t                w_gnt;

  // The grant is gated by reset so the *_rdy outputs stay 0 while reset is high.
  assign w_pick_en   = (r_state == ST_IDLE) && !r_cool && !reset;
  assign w_last_beat = bus_ret_valid && (r_beat == CNT_W'(LINE_WORDS - 1));

  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .clk         (clk),
    .reset       (reset),
`endif
    .i_en        (w_pick_en),
    .i_ic_rd_req (ic_rd_req),
    .i_dc_rd_req (dc_rd_req),
    .i_dc_wr_req (dc_wr_req),
    .o_gnt       (w_gnt)
  );

  always_comb begin
    w_next       = r_state;
    ic_rd_rdy    = 1'b0;
    dc_rd_rdy    = 1'b0;
    dc_wr_rdy    = 1'b0;
    ic_ret_valid = 1'b0;
    dc_ret_valid = 1'b0;
    ret_last     = 1'b0;
    ret_data     = '0;
    bus_rd_req   = 1'b0;
    bus_rd_addr  = '0;
    bus_wr_req   = 1'b0;
    bus_wr_addr  = '0;
    bus_wr_data  = '0;
    case (r_state)
      ST_IDLE: begin
        case (w_gnt)
          GNT_WR:  begin dc_wr_rdy = 1'b1; w_next = ST_WR_ADDR; end
          GNT_DC:  begin dc_rd_rdy = 1'b1; w_next = ST_RD_ADDR; end
          GNT_IC:  begin ic_rd_rdy = 1'b1; w_next = ST_RD_ADDR; end
          default: ;
        endcase
      end
      ST_RD_ADDR: begin
        bus_rd_req  = 1'b1;
        bus_rd_addr = r_addr;
        if (bus_rd_rdy) w_next = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        ret_data     = bus_ret_data;
        ic_ret_valid = bus_ret_valid && !r_is_dc;
        dc_ret_valid = bus_ret_valid && r_is_dc;
        ret_last     = w_last_beat;
        if (w_last_beat) w_next = ST_IDLE;
      end
      ST_WR_ADDR: begin
        bus_wr_req  = 1'b1;
        bus_wr_addr = r_addr;
        bus_wr_data = r_wdata;
        if (bus_wr_rdy) w_next = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (bus_wr_done) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_is_dc <= 1'b0;
      r_cool  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cool  <= (r_state != ST_IDLE) && (w_next == ST_IDLE);
      case (w_gnt)
        GNT_WR: begin
          r_addr  <= dc_wr_addr;
          r_wdata <= dc_wr_data;
          r_is_dc <= 1'b1;
        end
        GNT_DC: begin
          r_addr  <= dc_rd_addr;
          r_is_dc <= 1'b1;
        end
        GNT_IC: begin
          r_addr  <= ic_rd_addr;
          r_is_dc <= 1'b0;
        end
        default: ;
      endcase
      if (r_state == ST_RD_DATA && bus_ret_valid) begin
        r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            ic_rd_req;
  logic [31:0]     ic_rd_addr;
  logic            ic_rd_rdy;
  logic            ic_ret_valid;
  logic            dc_rd_req;
  logic [31:0]     dc_rd_addr;
  logic            dc_rd_rdy;
  logic            dc_ret_valid;
  logic            ret_last;
  logic [31:0]     ret_data;
  logic            dc_wr_req;
  logic [31:0]     dc_wr_addr;
  logic [32*LW-1:0] dc_wr_data;
  logic            dc_wr_rdy;
  logic            bus_rd_req;
  logic [31:0]     bus_rd_addr;
  logic            bus_rd_rdy;
  logic            bus_ret_valid;
  logic [31:0]     bus_ret_data;
  logic            bus_wr_req;
  logic [31:0]     bus_wr_addr;
  logic [32*LW-1:0] bus_wr_data;
  logic            bus_wr_rdy;
  logic            bus_wr_done;

  int errs = 0;
  int checks = 0;
  // Reference arbitration state: which read requester is favoured when both ask.
  bit m_fav_ic = 1'b1;

  cache_mem_arbiter #(.LINE_WORDS(LW)) dut (
    .clk(clk), .reset(reset),
    .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
    .ic_ret_valid(ic_ret_valid),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
    .dc_ret_valid(dc_ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
    .dc_wr_rdy(dc_wr_rdy),
    .bus_rd_req(bus_rd_req), .bus_rd_addr(bus_rd_addr), .bus_rd_rdy(bus_rd_rdy),
    .bus_ret_valid(bus_ret_valid), .bus_ret_data(bus_ret_data),
    .bus_wr_req(bus_wr_req), .bus_wr_addr(bus_wr_addr), .bus_wr_data(bus_wr_data),
    .bus_wr_rdy(bus_wr_rdy), .bus_wr_done(bus_wr_done)
  );

  always #5 clk = ~clk;

  wire [232-1:0] all_out = {ic_rd_rdy, ic_ret_valid, dc_rd_rdy, dc_ret_valid, ret_last,
                            ret_data, dc_wr_rdy, bus_rd_req, bus_rd_addr, bus_wr_req,
                            bus_wr_addr, bus_wr_data};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic half();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ic_rd_req = 0; ic_rd_addr = 0; dc_rd_req = 0; dc_rd_addr = 0;
    dc_wr_req = 0; dc_wr_addr = 0; dc_wr_data = '0;
    bus_rd_rdy = 0; bus_ret_valid = 0; bus_ret_data = 0;
    bus_wr_rdy = 0; bus_wr_done = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nxt();
    nxt();
    reset = 1'b0;
    m_fav_ic = 1'b1;
    nxt();
  endtask

  // Samples from the next negedge until some *_rdy appears (bounded).
  task automatic wait_grant(output logic [2:0] who);
    int k;
    k = 0;
    half();
    while (!(ic_rd_rdy || dc_rd_rdy || dc_wr_rdy) && k < 8) begin
      nxt();
      half();
      k++;
    end
    who = {dc_wr_rdy, dc_rd_rdy, ic_rd_rdy};
  endtask

  // Plays the memory side of a read burst that was just granted.
  task automatic read_burst(input bit exp_dc, input logic [31:0] exp_addr, input int stall,
                            input logic [31:0] d0, input bit rnd);
    int k;
    int gap;
    logic [31:0] d;
    m_fav_ic = ~m_fav_ic;
    k = 0;
    half();
    while (!bus_rd_req && k < 10) begin
      nxt();
      half();
      k++;
    end
    checks++;
    if (bus_rd_req !== 1'b1) begin
      errs++;
      $display("FAIL rd_req_wait: bus_rd_req=%b want 1", bus_rd_req);
      return;
    end
    checks++;
    if (bus_rd_addr !== exp_addr) begin
      errs++;
      $display("FAIL rd_addr: got %h want %h", bus_rd_addr, exp_addr);
    end
    for (int i = 0; i < stall; i++) begin
      dc_rd_addr = $urandom;
      ic_rd_addr = $urandom;
      nxt();
      half();
      checks++;
      if (bus_rd_req !== 1'b1 || bus_rd_addr !== exp_addr) begin
        errs++;
        $display("FAIL rd_hold cycle %0d: req=%b addr=%h want req=1 addr=%h",
                 i, bus_rd_req, bus_rd_addr, exp_addr);
      end
    end
    bus_rd_rdy = 1'b1;
    nxt();
    bus_rd_rdy = 1'b0;
    for (int b = 0; b < LW; b++) begin
      gap = rnd ? $urandom_range(0, 2) : 0;
      for (int g = 0; g < gap; g++) begin
        bus_ret_valid = 1'b0;
        bus_ret_data = $urandom;
        half();
        checks++;
        if (ic_ret_valid !== 1'b0 || dc_ret_valid !== 1'b0) begin
          errs++;
          $display("FAIL ret_gap: ic=%b dc=%b want 0 0", ic_ret_valid, dc_ret_valid);
        end
        nxt();
      end
      d = rnd ? $urandom : d0 + b;
      bus_ret_valid = 1'b1;
      bus_ret_data = d;
      half();
      checks++;
      if (ic_ret_valid !== !exp_dc || dc_ret_valid !== exp_dc || ret_data !== d ||
          ret_last !== (b == LW - 1)) begin
        errs++;
        $display("FAIL beat %0d: ic=%b dc=%b last=%b data=%h want ic=%b dc=%b last=%b data=%h",
                 b, ic_ret_valid, dc_ret_valid, ret_last, ret_data,
                 !exp_dc, exp_dc, (b == LW - 1), d);
      end
      nxt();
      bus_ret_valid = 1'b0;
    end
  endtask

  // Plays the memory side of a write burst; also pulses bus_ret_valid
  // while waiting for completion, which must not reach either cache.
  task automatic write_burst(input logic [31:0] exp_addr, input logic [32*LW-1:0] exp_data,
                             input int stall, input int resp_delay);
    int k;
    k = 0;
    half();
    while (!bus_wr_req && k < 10) begin
      nxt();
      half();
      k++;
    end
    checks++;
    if (bus_wr_req !== 1'b1 || bus_rd_req !== 1'b0) begin
      errs++;
      $display("FAIL wr_req_wait: wr_req=%b rd_req=%b want 1 0", bus_wr_req, bus_rd_req);
      return;
    end
    checks++;
    if (bus_wr_addr !== exp_addr || bus_wr_data !== exp_data) begin
      errs++;
      $display("FAIL wr_addr_data: got %h/%h want %h/%h", bus_wr_addr, bus_wr_data,
               exp_addr, exp_data);
    end
    for (int i = 0; i < stall; i++) begin
      nxt();
      half();
      checks++;
      if (bus_wr_req !== 1'b1 || bus_wr_addr !== exp_addr || bus_wr_data !== exp_data) begin
        errs++;
        $display("FAIL wr_hold cycle %0d: req=%b addr=%h want 1 %h", i, bus_wr_req,
                 bus_wr_addr, exp_addr);
      end
    end
    bus_wr_rdy = 1'b1;
    nxt();
    bus_wr_rdy = 1'b0;
    for (int i = 0; i < resp_delay; i++) begin
      bus_ret_valid = 1'b1;
      half();
      checks++;
      if (ic_ret_valid | dc_ret_valid | bus_rd_req | bus_wr_req | ret_last) begin
        errs++;
        $display("FAIL wr_resp_quiet: ic=%b dc=%b rd=%b wr=%b last=%b want all 0",
                 ic_ret_valid, dc_ret_valid, bus_rd_req, bus_wr_req, ret_last);
      end
      nxt();
      bus_ret_valid = 1'b0;
    end
    bus_wr_done = 1'b1;
    nxt();
    bus_wr_done = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    ic_rd_req = 1'b1;
    dc_rd_req = 1'b1;
    dc_wr_req = 1'b1;
    bus_ret_valid = 1'b1;
    bus_ret_data = 32'hDEADBEEF;
    nxt();
    half();
    checks++;
    if (all_out !== '0) begin
      errs++;
      $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    nxt();
    idle_inputs();
    reset = 1'b0;
    m_fav_ic = 1'b1;
    half();
    checks++;
    if (all_out !== '0) begin
      errs++;
      $display("FAIL idle_outputs: got %h want 0", all_out);
    end
    nxt();
  endtask

  task automatic test_ic_refill();
    logic [2:0] who;
    ic_rd_req = 1'b1;
    ic_rd_addr = 32'h1FC00000;
    wait_grant(who);
    checks++;
    if (who !== 3'b001) begin
      errs++;
      $display("FAIL ic_grant: got %b want 001", who);
    end
    nxt();
    ic_rd_req = 1'b0;
    ic_rd_addr = 32'h12345678;
    read_burst(1'b0, 32'h1FC00000, 2, 32'hA0, 1'b0);
  endtask

  task automatic test_wr_before_rd();
    logic [2:0] who;
    logic [32*LW-1:0] wd;
    wd = {$urandom, $urandom, $urandom, $urandom};
    dc_wr_req = 1'b1;
    dc_wr_addr = 32'h00001000;
    dc_wr_data = wd;
    dc_rd_req = 1'b1;
    dc_rd_addr = 32'h00001000;
    wait_grant(who);
    checks++;
    if (who !== 3'b100) begin
      errs++;
      $display("FAIL wr_first_grant: got %b want 100", who);
    end
    nxt();
    dc_wr_req = 1'b0;
    dc_wr_data = '0;
    write_burst(32'h00001000, wd, 1, 2);
    half();
    checks++;
    if (dc_rd_rdy !== 1'b0 || bus_rd_req !== 1'b0) begin
      errs++;
      $display("FAIL idle_gap: rdy=%b rd_req=%b want 0 0", dc_rd_rdy, bus_rd_req);
    end
    nxt();
    half();
    checks++;
    if (dc_rd_rdy !== 1'b1) begin
      errs++;
      $display("FAIL rd_after_wr_grant: got %b want 1", dc_rd_rdy);
    end
    nxt();
    dc_rd_req = 1'b0;
    read_burst(1'b1, 32'h00001000, 0, 0, 1'b1);
  endtask

  task automatic test_stall();
    logic [2:0] who;
    logic [31:0] a;
    a = $urandom & 32'hFFFF_FFF0;
    dc_rd_req = 1'b1;
    dc_rd_addr = a;
    wait_grant(who);
    checks++;
    if (who !== 3'b010) begin
      errs++;
      $display("FAIL stall_grant: got %b want 010", who);
    end
    nxt();
    dc_rd_req = 1'b0;
    read_burst(1'b1, a, 10, 0, 1'b1);
  endtask

  task automatic test_arb_order();
    logic [2:0] who;
    logic [2:0] exp;
    do_reset();
    ic_rd_req = 1'b1;
    dc_rd_req = 1'b1;
    for (int t = 0; t < 4; t++) begin
      ic_rd_addr = 32'h0000_0100 + 32'(t * 16);
      dc_rd_addr = 32'h8000_0200 + 32'(t * 16);
`ifdef MEM_ARB_RR_EN
      exp = m_fav_ic ? 3'b001 : 3'b010;
`else
      exp = 3'b010;
`endif
      wait_grant(who);
      checks++;
      if (who !== exp) begin
        errs++;
        $display("FAIL arb_order txn %0d: got %b want %b", t, who, exp);
      end
      nxt();
      if (exp == 3'b001) read_burst(1'b0, 32'h0000_0100 + 32'(t * 16), 0, 0, 1'b1);
      else               read_burst(1'b1, 32'h8000_0200 + 32'(t * 16), 0, 0, 1'b1);
    end
    ic_rd_req = 1'b0;
    dc_rd_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [2:0] who;
    dc_rd_req = 1'b1;
    dc_rd_addr = 32'h0000_4440;
    wait_grant(who);
    checks++;
    if (who !== 3'b010) begin
      errs++;
      $display("FAIL mid_grant: got %b want 010", who);
    end
    nxt();
    dc_rd_req = 1'b0;
    bus_rd_rdy = 1'b1;
    nxt();
    bus_rd_rdy = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus_ret_valid = 1'b1;
      bus_ret_data = $urandom;
      nxt();
    end
    reset = 1'b1;
    ic_rd_req = 1'b1;
    ic_rd_addr = 32'h0000_7770;
    #1;
    checks++;
    if (all_out !== '0) begin
      errs++;
      $display("FAIL reset_async_outputs: got %h want 0", all_out);
    end
    nxt();
    half();
    checks++;
    if (all_out !== '0) begin
      errs++;
      $display("FAIL reset_next_cycle_outputs: got %h want 0", all_out);
    end
    nxt();
    reset = 1'b0;
    bus_ret_valid = 1'b0;
    m_fav_ic = 1'b1;
    wait_grant(who);
    checks++;
    if (who !== 3'b001) begin
      errs++;
      $display("FAIL post_reset_grant: got %b want 001", who);
    end
    nxt();
    ic_rd_req = 1'b0;
    read_burst(1'b0, 32'h0000_7770, 1, 0, 1'b1);
  endtask

  task automatic test_random();
    logic [2:0] who;
    logic [2:0] exp;
    logic [2:0] r;
    logic [31:0] ia, da, wa;
    logic [32*LW-1:0] wd;
    for (int t = 0; t < 40; t++) begin
      r = 3'($urandom_range(1, 7));
      ia = $urandom; da = $urandom; wa = $urandom;
      wd = {$urandom, $urandom, $urandom, $urandom};
      ic_rd_req = r[0]; ic_rd_addr = ia;
      dc_rd_req = r[1]; dc_rd_addr = da;
      dc_wr_req = r[2]; dc_wr_addr = wa; dc_wr_data = wd;
      if (r[2])              exp = 3'b100;
      else if (r[0] && r[1])
`ifdef MEM_ARB_RR_EN
                             exp = m_fav_ic ? 3'b001 : 3'b010;
`else
                             exp = 3'b010;
`endif
      else if (r[1])         exp = 3'b010;
      else                   exp = 3'b001;
      wait_grant(who);
      checks++;
      if (who !== exp) begin
        errs++;
        $display("FAIL rand_grant txn %0d reqs=%b: got %b want %b", t, r, who, exp);
      end
      nxt();
      ic_rd_req = 1'b0; dc_rd_req = 1'b0; dc_wr_req = 1'b0;
      case (exp)
        3'b100:  write_burst(wa, wd, $urandom_range(0, 3), $urandom_range(0, 3));
        3'b010:  read_burst(1'b1, da, $urandom_range(0, 3), 0, 1'b1);
        default: read_burst(1'b0, ia, $urandom_range(0, 3), 0, 1'b1);
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_ic_refill();
    test_wr_before_rd();
    test_stall();
    test_arb_order();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
